branch_resolve_queue: RTL and testbench

In-order queue in the fetch stage. It records every branch prediction issued by fetch and retires them as execute resolves branches. On each retirement it drives the registered update to the 2-bit saturating-counter predictor (valid, actual outcome, stored counter snapshot). On a misprediction it raises a one-cycle redirect with the recovery PC and discards all younger, wrong-path entries.

---
 rtl/branch_resolve_queue.sv | 149 ++++++++++++++
 tb/tb_branch_resolve_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order record of fetch-stage branch predictions.
// Each valid resolve retires the oldest entry and produces a registered
// predictor update. A misprediction also produces a one-cycle redirect to
// the stored recovery PC and flushes every younger, wrong-path entry.
module branch_resolve_queue #(
  parameter int W_BRID = 2,
  parameter int W_ADDR = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W_BRID-1:0]        push_id_i,
  input  logic [W_ADDR-1:0]        push_alt_pc_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic                     resolve_i,
  input  logic                     resolve_taken_i,
  output logic                     upd_v_o,
  output logic                     upd_branch_o,
  output logic [W_BRID-1:0]        upd_id_o,
  output logic                     mispredict_o,
  output logic [W_ADDR-1:0]        redirect_pc_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; contents are don't-care after reset, so no reset here.
  logic [W_BRID-1:0] id_mem_q [DEPTH];
  logic [W_ADDR-1:0] pc_mem_q [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              upd_v_q, upd_v_d;
  logic              upd_branch_q, upd_branch_d;
  logic [W_BRID-1:0] upd_id_q, upd_id_d;
  logic              mis_q, mis_d;
  logic [W_ADDR-1:0] redir_q, redir_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              mis_s;
  logic              push_ok_s;
  logic              drop_s;
  logic [W_BRID-1:0] head_id_s;
  logic [W_ADDR-1:0] head_pc_s;

  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == CW'(DEPTH));
  assign head_id_s = id_mem_q[rd_ptr_q];
  assign head_pc_s = pc_mem_q[rd_ptr_q];

  // Classify this cycle's pop, mispredict, accepted push and dropped push.
  always_comb begin
    pop_s     = resolve_i & ~empty_s;
    mis_s     = pop_s & (head_id_s[W_BRID-1] ^ resolve_taken_i);
    // A push alongside a mispredict is wrong-path: neither stored nor counted as overflow.
    push_ok_s = push_i & ~mis_s & (~full_s | pop_s);
    drop_s    = push_i & ~mis_s & full_s & ~pop_s;
  end

  // Next-state for pointers, occupancy, retirement outputs and sticky flags.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    upd_v_d      = pop_s;
    upd_branch_d = upd_branch_q;
    upd_id_d     = upd_id_q;
    mis_d        = mis_s;
    redir_d      = redir_q;
    ovf_d        = ovf_q | drop_s;
    unf_d        = unf_q | (resolve_i & empty_s);

    if (pop_s) begin
      upd_branch_d = resolve_taken_i;
      upd_id_d     = head_id_s;
    end else begin
      upd_branch_d = upd_branch_q;
      upd_id_d     = upd_id_q;
    end

    if (mis_s) begin
      // Flush: everything younger than the resolved branch is wrong-path.
      redir_d  = head_pc_s;
      count_d  = {CW{1'b0}};
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end else begin
      redir_d  = redir_q;
      rd_ptr_d = rd_ptr_q + (pop_s ? PW'(1) : PW'(0));
      wr_ptr_d = wr_ptr_q + (push_ok_s ? PW'(1) : PW'(0));
      count_d  = count_q + (push_ok_s ? CW'(1) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    end
  end

  // Write an accepted push into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      id_mem_q[wr_ptr_q] <= push_id_i;
      pc_mem_q[wr_ptr_q] <= push_alt_pc_i;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= {PW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      upd_v_q      <= 1'b0;
      upd_branch_q <= 1'b0;
      upd_id_q     <= {W_BRID{1'b0}};
      mis_q        <= 1'b0;
      redir_q      <= {W_ADDR{1'b0}};
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      upd_v_q      <= upd_v_d;
      upd_branch_q <= upd_branch_d;
      upd_id_q     <= upd_id_d;
      mis_q        <= mis_d;
      redir_q      <= redir_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign full_o        = full_s;
  assign count_o       = count_q;
  assign upd_v_o       = upd_v_q;
  assign upd_branch_o  = upd_branch_q;
  assign upd_id_o      = upd_id_q;
  assign mispredict_o  = mis_q;
  assign redirect_pc_o = redir_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int W_BRID = 2;
  localparam int W_ADDR = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              push_i;
  logic [W_BRID-1:0] push_id_i;
  logic [W_ADDR-1:0] push_alt_pc_i;
  logic              full_o;
  logic [CW-1:0]     count_o;
  logic              resolve_i;
  logic              resolve_taken_i;
  logic              upd_v_o;
  logic              upd_branch_o;
  logic [W_BRID-1:0] upd_id_o;
  logic              mispredict_o;
  logic [W_ADDR-1:0] redirect_pc_o;
  logic              overflow_o;
  logic              underflow_o;

  int checks;
  int errors;

  branch_resolve_queue #(.W_BRID(W_BRID), .W_ADDR(W_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .push_i(push_i), .push_id_i(push_id_i), .push_alt_pc_i(push_alt_pc_i),
    .full_o(full_o), .count_o(count_o),
    .resolve_i(resolve_i), .resolve_taken_i(resolve_taken_i),
    .upd_v_o(upd_v_o), .upd_branch_o(upd_branch_o), .upd_id_o(upd_id_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W_BRID-1:0] id;
    logic [W_ADDR-1:0] pc;
  } ent_t;

  ent_t              mq[$];
  logic              exp_upd_v;
  logic              exp_branch;
  logic [W_BRID-1:0] exp_id;
  logic              exp_mis;
  logic [W_ADDR-1:0] exp_redir;
  logic              exp_ovf;
  logic              exp_unf;

  task automatic model_clear();
    mq.delete();
    exp_upd_v  = 1'b0;
    exp_branch = 1'b0;
    exp_id     = '0;
    exp_mis    = 1'b0;
    exp_redir  = '0;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
  endtask

  task automatic model_cycle(input logic p, input logic [W_BRID-1:0] id,
                             input logic [W_ADDR-1:0] pc, input logic r, input logic t);
    ent_t e;
    logic flushed;
    flushed   = 1'b0;
    exp_upd_v = 1'b0;
    exp_mis   = 1'b0;
    if (r) begin
      if (mq.size() > 0) begin
        e          = mq.pop_front();
        exp_upd_v  = 1'b1;
        exp_branch = t;
        exp_id     = e.id;
        if (e.id[W_BRID-1] != t) begin
          exp_mis   = 1'b1;
          exp_redir = e.pc;
          mq.delete();
          flushed   = 1'b1;
        end
      end else begin
        exp_unf = 1'b1;
      end
    end
    if (p && !flushed) begin
      if (mq.size() < DEPTH) mq.push_back('{id: id, pc: pc});
      else exp_ovf = 1'b1;
    end
  endtask

  // One clock cycle of stimulus; inputs change one time unit after the edge.
  task automatic step(input logic p, input logic [W_BRID-1:0] id,
                      input logic [W_ADDR-1:0] pc, input logic r, input logic t);
    push_i          = p;
    push_id_i       = id;
    push_alt_pc_i   = pc;
    resolve_i       = r;
    resolve_taken_i = t;
    @(posedge clk);
    model_cycle(p, id, pc, r, t);
    #1;
    push_i    = 1'b0;
    resolve_i = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({count_o, full_o, upd_v_o, upd_branch_o, upd_id_o, mispredict_o,
         redirect_pc_o, overflow_o, underflow_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: count=%0d full=%0d upd_v=%0d mis=%0d redir=%h ovf=%0d unf=%0d, expected all 0",
               count_o, full_o, upd_v_o, mispredict_o, redirect_pc_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b11, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    checks++;
    if (count_o !== 3'd4 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: count=%0d full=%0d, expected 4 1", count_o, full_o);
    end
    step(1'b1, 2'b11, 32'h110, 1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL overflow_push: ovf=%0d count=%0d, expected 1 4", overflow_o, count_o);
    end
  endtask

  task automatic test_resolve_correct();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1);
      checks++;
      if (upd_v_o !== 1'b1 || upd_id_o !== 2'b11 || upd_branch_o !== 1'b1 || mispredict_o !== 1'b0) begin
        errors++;
        $display("FAIL correct_resolve_%0d: upd_v=%0d id=%b br=%0d mis=%0d, expected 1 11 1 0",
                 i, upd_v_o, upd_id_o, upd_branch_o, mispredict_o);
      end
    end
    step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count_o !== 3'd0 || upd_v_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d upd_v=%0d, expected 0 0", count_o, upd_v_o);
    end
  endtask

  task automatic test_mispredict();
    step(1'b1, 2'b10, 32'h200, 1'b0, 1'b0);
    step(1'b1, 2'b01, 32'h300, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    checks++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h200 || upd_id_o !== 2'b10 ||
        upd_branch_o !== 1'b0 || count_o !== 3'd0 || upd_v_o !== 1'b1) begin
      errors++;
      $display("FAIL mispredict: mis=%0d redir=%h id=%b br=%0d count=%0d upd_v=%0d, expected 1 200 10 0 0 1",
               mispredict_o, redirect_pc_o, upd_id_o, upd_branch_o, count_o, upd_v_o);
    end
    step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    checks++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h200 || upd_v_o !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_pulse_end: mis=%0d redir=%h upd_v=%0d, expected 0 200 0",
               mispredict_o, redirect_pc_o, upd_v_o);
    end
  endtask

  task automatic test_concurrent();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b11, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h500, 1'b1, 1'b1);
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b0 || upd_v_o !== 1'b1 || mispredict_o !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%0d upd_v=%0d mis=%0d, expected 4 0 1 0",
               count_o, overflow_o, upd_v_o, mispredict_o);
    end
    step(1'b1, 2'b00, 32'h600, 1'b1, 1'b0);
    checks++;
    if (count_o !== 3'd0 || overflow_o !== 1'b0 || mispredict_o !== 1'b1 || redirect_pc_o !== 32'h104) begin
      errors++;
      $display("FAIL mis_with_push: count=%0d ovf=%0d mis=%0d redir=%h, expected 0 0 1 104",
               count_o, overflow_o, mispredict_o, redirect_pc_o);
    end
    step(1'b1, 2'b10, 32'h700, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1);
    checks++;
    if (upd_id_o !== 2'b10 || upd_v_o !== 1'b1) begin
      errors++;
      $display("FAIL wrong_path_dropped: id=%b upd_v=%0d, expected 10 1", upd_id_o, upd_v_o);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1);
    checks++;
    if (upd_v_o !== 1'b0 || underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow: upd_v=%0d unf=%0d, expected 0 1", upd_v_o, underflow_o);
    end
    step(1'b1, 2'b01, 32'h800, 1'b1, 1'b0);
    checks++;
    if (count_o !== 3'd1 || upd_v_o !== 1'b0 || underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL push_on_empty_resolve: count=%0d upd_v=%0d unf=%0d, expected 1 0 1",
               count_o, upd_v_o, underflow_o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 32'h900 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1);
    // Pending update pulse visible now; reset lands mid-cycle.
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({count_o, full_o, upd_v_o, upd_branch_o, upd_id_o, mispredict_o,
         redirect_pc_o, overflow_o, underflow_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: count=%0d upd_v=%0d br=%0d id=%b unf=%0d, expected all 0",
               count_o, upd_v_o, upd_branch_o, upd_id_o, underflow_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    logic [W_BRID-1:0] nid;
    nid = W_BRID'($urandom_range(0, 3));
    step(1'b1, nid, 32'hA00, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      nid = W_BRID'($urandom_range(0, 3));
      // Resolve with the predicted direction so nothing is flushed.
      step(1'b1, nid, 32'hA04 + 32'(4 * i), 1'b1, mq[0].id[W_BRID-1]);
      checks++;
      if (upd_v_o !== 1'b1 || upd_id_o !== exp_id || mispredict_o !== 1'b0 || count_o !== 3'd1) begin
        errors++;
        $display("FAIL wrap_order_%0d: upd_v=%0d id=%b mis=%0d count=%0d, expected 1 %b 0 1",
                 i, upd_v_o, upd_id_o, mispredict_o, count_o, exp_id);
      end
    end
  endtask

  task automatic test_random();
    logic p, r, t;
    logic [W_BRID-1:0] id;
    logic [W_ADDR-1:0] pc;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5);
      t  = 1'($urandom);
      id = W_BRID'($urandom);
      pc = $urandom;
      step(p, id, pc, r, t);
      checks++;
      if (count_o !== CW'(mq.size()) || full_o !== (mq.size() == DEPTH) ||
          upd_v_o !== exp_upd_v || mispredict_o !== exp_mis || redirect_pc_o !== exp_redir ||
          overflow_o !== exp_ovf || underflow_o !== exp_unf ||
          (exp_upd_v && (upd_id_o !== exp_id || upd_branch_o !== exp_branch))) begin
        errors++;
        $display("FAIL random_%0d: count=%0d/%0d upd_v=%0d/%0d id=%b/%b br=%0d/%0d mis=%0d/%0d redir=%h/%h ovf=%0d/%0d unf=%0d/%0d (got/expected)",
                 i, count_o, mq.size(), upd_v_o, exp_upd_v, upd_id_o, exp_id, upd_branch_o, exp_branch,
                 mispredict_o, exp_mis, redirect_pc_o, exp_redir, overflow_o, exp_ovf, underflow_o, exp_unf);
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    push_i          = 1'b0;
    push_id_i       = '0;
    push_alt_pc_i   = '0;
    resolve_i       = 1'b0;
    resolve_taken_i = 1'b0;
    model_clear();
    #1;
    test_reset();
    test_fill_overflow();
    test_resolve_correct();
    test_mispredict();
    test_concurrent();
    test_underflow();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
